// File: rtl/shop_pkg.sv
// Shared constants and FSM encoding for the shop session controller.
package shop_pkg;

   localparam logic [3:0] OP_NONE    = 4'd0;
   localparam logic [3:0] OP_LOGIN   = 4'd1;
   localparam logic [3:0] OP_LOGOUT  = 4'd2;
   localparam logic [3:0] OP_ADDUSR  = 4'd3;
   localparam logic [3:0] OP_DELUSR  = 4'd4;
   localparam logic [3:0] OP_ADDITEM = 4'd5;
   localparam logic [3:0] OP_DELITEM = 4'd6;
   localparam logic [3:0] OP_BUY     = 4'd7;

   localparam logic [23:0] ST_OK  = "OK ";
   localparam logic [23:0] ST_ERR = "ERR";
   localparam logic [23:0] ST_DEN = "DEN";
   localparam logic [23:0] ST_TMO = "TMO";

   localparam logic [1:0] IOP_ADD = 2'd0;
   localparam logic [1:0] IOP_DEL = 2'd1;
   localparam logic [1:0] IOP_BUY = 2'd2;

   localparam logic [23:0] ADMIN_NAME = "Adm";

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ITEM_REQ,
      S_WAIT,
      S_RESP
   } state_t;

endpackage

// File: rtl/shop_user_table.sv
// User table: valid+name slots, slot 0 preloaded with the admin name.
module shop_user_table #(
   parameter int                MAX_USERS  = 5,
   parameter int                NAME_W     = 24,
   parameter logic [NAME_W-1:0] ADMIN_USER = "Adm"
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NAME_W-1:0] i_name,
   input  logic              i_add,
   input  logic              i_del,
   input  logic [2:0]        i_del_slot,
   output logic              o_match,
   output logic [2:0]        o_match_slot,
   output logic              o_full,
   output logic [2:0]        o_free_slot
);

   logic [MAX_USERS-1:0] valid;
   logic [NAME_W-1:0]    names [MAX_USERS];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid <= '0;
         valid[0] <= 1'b1;
         for (int i = 0; i < MAX_USERS; i++) names[i] <= '0;
         names[0] <= ADMIN_USER;
      end else begin
         if (i_add && !o_full) begin
            valid[o_free_slot] <= 1'b1;
            names[o_free_slot] <= i_name;
         end
         if (i_del) valid[i_del_slot] <= 1'b0;
      end
   end

   // Descending scan so the lowest slot wins both searches
   always_comb begin
      o_match      = 1'b0;
      o_match_slot = '0;
      o_full       = 1'b1;
      o_free_slot  = '0;
      for (int i = MAX_USERS - 1; i >= 0; i--) begin
         if (valid[i] && names[i] == i_name) begin
            o_match      = 1'b1;
            o_match_slot = 3'(i);
         end
         if (!valid[i]) begin
            o_full      = 1'b0;
            o_free_slot = 3'(i);
         end
      end
   end

endmodule

// File: rtl/shop_session_ctrl.sv
// Command sequencer: login session, user admin and item-store forwarding.
import shop_pkg::*;

module shop_session_ctrl #(
   parameter int                      I_A_NUM_BITS   = 24,
   parameter int                      I_U_NUM_BITS   = 4,
   parameter int                      O_A_NUM_BITS   = 24,
   parameter int                      MAX_USERS      = 5,
   parameter logic [I_A_NUM_BITS-1:0] ADMIN_USERNAME = ADMIN_NAME,
   parameter int                      ACK_TIMEOUT    = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_rdy,
   input  logic [I_U_NUM_BITS-1:0] i_u,
   input  logic [I_A_NUM_BITS-1:0] i_a,
   output logic [O_A_NUM_BITS-1:0] o_a,
   output logic                    o_done,
   output logic                    o_busy,
   output logic                    o_item_req,
   output logic [1:0]              o_item_op,
   output logic [I_A_NUM_BITS-1:0] o_item_name,
   output logic [2:0]              o_item_user,
   input  logic                    i_item_ack,
   input  logic                    i_item_ok
);

   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   state_t                  state;
   logic                    rdy_q;
   logic [I_U_NUM_BITS-1:0] cmd_op;
   logic [I_A_NUM_BITS-1:0] cmd_name;
   logic                    sess_valid;
   logic [2:0]              sess_slot;
   logic [O_A_NUM_BITS-1:0] result;
   logic [TMO_W-1:0]        tmo_cnt;

   logic                    match, full;
   logic [2:0]              match_slot, free_slot;
   logic                    is_admin, is_user;
   logic                    dec_login, dec_logout, dec_add, dec_del;
   logic                    dec_item;
   logic [1:0]              dec_iop;
   logic [O_A_NUM_BITS-1:0] dec_status;

   assign is_admin    = sess_valid && (sess_slot == 3'd0);
   assign is_user     = sess_valid && (sess_slot != 3'd0);
   assign o_item_name = cmd_name;

   shop_user_table #(
      .MAX_USERS  (MAX_USERS),
      .NAME_W     (I_A_NUM_BITS),
      .ADMIN_USER (ADMIN_USERNAME)
   ) u_table (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_name       (cmd_name),
      .i_add        (dec_add && state == S_DECODE),
      .i_del        (dec_del && state == S_DECODE),
      .i_del_slot   (match_slot),
      .o_match      (match),
      .o_match_slot (match_slot),
      .o_full       (full),
      .o_free_slot  (free_slot)
   );

   always_comb begin
      dec_status = ST_ERR;
      dec_login  = 1'b0;
      dec_logout = 1'b0;
      dec_add    = 1'b0;
      dec_del    = 1'b0;
      dec_item   = 1'b0;
      dec_iop    = IOP_ADD;
      unique case (cmd_op)
         OP_NONE: dec_status = ST_OK;
         OP_LOGIN:
            if (!sess_valid && match) begin
               dec_login  = 1'b1;
               dec_status = ST_OK;
            end
         OP_LOGOUT:
            if (sess_valid) begin
               dec_logout = 1'b1;
               dec_status = ST_OK;
            end
         OP_ADDUSR:
            if (!is_admin) dec_status = ST_DEN;
            else if (!match && !full) begin
               dec_add    = 1'b1;
               dec_status = ST_OK;
            end
         // The admin slot is protected by name, before any lookup
         OP_DELUSR:
            if (!is_admin || cmd_name == ADMIN_USERNAME)
               dec_status = ST_DEN;
            else if (match) begin
               dec_del    = 1'b1;
               dec_status = ST_OK;
            end
         OP_ADDITEM, OP_DELITEM: begin
            dec_iop = (cmd_op == OP_ADDITEM) ? IOP_ADD : IOP_DEL;
            if (!is_admin) dec_status = ST_DEN;
            else dec_item = 1'b1;
         end
         OP_BUY: begin
            dec_iop = IOP_BUY;
            if (!is_user) dec_status = ST_DEN;
            else dec_item = 1'b1;
         end
         default: dec_status = ST_ERR;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= S_IDLE;
         rdy_q       <= 1'b0;
         cmd_op      <= '0;
         cmd_name    <= '0;
         sess_valid  <= 1'b0;
         sess_slot   <= '0;
         result      <= '0;
         tmo_cnt     <= '0;
         o_a         <= '0;
         o_done      <= 1'b0;
         o_busy      <= 1'b0;
         o_item_req  <= 1'b0;
         o_item_op   <= '0;
         o_item_user <= '0;
      end else begin
         rdy_q  <= i_rdy;
         o_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               o_busy <= 1'b0;
               if (i_rdy && !rdy_q) begin
                  cmd_op   <= i_u;
                  cmd_name <= i_a;
                  o_busy   <= 1'b1;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               result <= dec_status;
               if (dec_login) begin
                  sess_valid <= 1'b1;
                  sess_slot  <= match_slot;
               end
               if (dec_logout) sess_valid <= 1'b0;
               if (dec_item) begin
                  o_item_op   <= dec_iop;
                  o_item_user <= sess_slot;
                  state       <= S_ITEM_REQ;
               end else begin
                  state <= S_RESP;
               end
            end
            S_ITEM_REQ: begin
               o_item_req <= 1'b1;
               tmo_cnt    <= '0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if (i_item_ack) begin
                  o_item_req <= 1'b0;
                  result     <= i_item_ok ? ST_OK : ST_ERR;
                  state      <= S_RESP;
               end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                  o_item_req <= 1'b0;
                  result     <= ST_TMO;
                  state      <= S_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_RESP: begin
               o_a    <= result;
               o_done <= 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shop_session_ctrl.sv
// Directed self-checking bench for shop_session_ctrl.
module tb_shop_session_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b0;
   logic [3:0]  u = '0;
   logic [23:0] a = '0;
   logic [23:0] o_a;
   logic        o_done, o_busy, o_item_req;
   logic [1:0]  o_item_op;
   logic [23:0] o_item_name;
   logic [2:0]  o_item_user;
   logic        ack = 1'b0;
   logic        ok = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   shop_session_ctrl dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_rdy       (rdy),
      .i_u         (u),
      .i_a         (a),
      .o_a         (o_a),
      .o_done      (o_done),
      .o_busy      (o_busy),
      .o_item_req  (o_item_req),
      .o_item_op   (o_item_op),
      .o_item_name (o_item_name),
      .o_item_user (o_item_user),
      .i_item_ack  (ack),
      .i_item_ok   (ok)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   // Non-item command: done must appear on the third edge after i_rdy rises
   task automatic cmd(input string tag, input logic [3:0] op,
                      input logic [23:0] name, input logic [23:0] exp);
      @(negedge clk);
      u = op; a = name; rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0;
      chk({tag, " busy"}, o_busy, 1);
      @(posedge clk); #1;
      chk({tag, " early"}, o_done, 0);
      @(posedge clk); #1;
      chk({tag, " done"}, o_done, 1);
      chk({tag, " o_a"}, o_a, exp);
   endtask

   task automatic item_cmd(input string tag, input logic [3:0] op,
                           input logic [23:0] name, input int ack_dly,
                           input logic ack_ok, input logic [1:0] exp_op,
                           input logic [2:0] exp_user,
                           input logic [23:0] exp);
      int  n;
      bit  seen;
      @(negedge clk);
      u = op; a = name; rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge clk); #1;
         seen = o_item_req;
      end
      chk({tag, " req"}, seen, 1);
      chk({tag, " op"}, o_item_op, exp_op);
      chk({tag, " name"}, o_item_name, name);
      chk({tag, " user"}, o_item_user, exp_user);
      if (ack_dly >= 0) begin
         repeat (ack_dly) @(posedge clk);
         #1;
         ack = 1'b1; ok = ack_ok;
         @(posedge clk); #1;
         ack = 1'b0; ok = 1'b0;
         chk({tag, " req drop"}, o_item_req, 0);
      end else begin
         n = 1;
         while (o_item_req && n < 40) begin
            @(posedge clk); #1;
            if (o_item_req) n++;
         end
         chk({tag, " req hold"}, n, 16);
      end
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge clk); #1;
         seen = o_done;
      end
      chk({tag, " done"}, seen, 1);
      chk({tag, " o_a"}, o_a, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      repeat (3) @(posedge clk);
      #1;
      chk("rst o_a", o_a, 0);
      chk("rst done", o_done, 0);
      chk("rst busy", o_busy, 0);
      chk("rst req", o_item_req, 0);
      chk("rst op", o_item_op, 0);
      chk("rst name", o_item_name, 0);
      chk("rst user", o_item_user, 0);
      @(negedge clk);
      rst = 1'b0;

      cmd("login adm", 4'd1, "Adm", "OK ");
      cmd("add bob", 4'd3, "bob", "OK ");
      for (int i = 0; i < 3; i++) cmd("add bob dup", 4'd3, "bob", "ERR");
      cmd("add u2", 4'd3, "u2 ", "OK ");
      cmd("add u3", 4'd3, "u3 ", "OK ");
      cmd("add u4", 4'd3, "u4 ", "OK ");
      cmd("add u5 full", 4'd3, "u5 ", "ERR");
      cmd("adm buy", 4'd7, "pen", "DEN");
      cmd("del adm", 4'd4, "Adm", "DEN");
      item_cmd("additem", 4'd5, "pen", 5, 1'b1, 2'd0, 3'd0, "OK ");
      item_cmd("delitem nok", 4'd6, "ink", 2, 1'b0, 2'd1, 3'd0, "ERR");
      cmd("del u4", 4'd4, "u4 ", "OK ");
      cmd("del u4 again", 4'd4, "u4 ", "ERR");
      cmd("add u5 reuse", 4'd3, "u5 ", "OK ");
      cmd("login twice", 4'd1, "bob", "ERR");
      cmd("logout", 4'd2, "Adm", "OK ");
      cmd("logout none", 4'd2, "Adm", "ERR");
      cmd("login ghost", 4'd1, "zzz", "ERR");
      cmd("login bob", 4'd1, "bob", "OK ");
      cmd("bob addusr", 4'd3, "xyz", "DEN");
      cmd("bob additem", 4'd5, "pen", "DEN");
      item_cmd("buy tmo", 4'd7, "pen", -1, 1'b0, 2'd2, 3'd1, "TMO");
      cmd("op12", 4'd12, "bob", "ERR");

      @(negedge clk);
      u = 4'd7; a = "cup"; rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (o_done) dones++;
         if (i == 6) rdy = 1'b1;
         if (i == 8) rdy = 1'b0;
      end
      chk("wait pulse dones", dones, 1);
      chk("wait pulse o_a", o_a, "TMO");

      @(negedge clk);
      u = 4'd0; a = "bob"; rdy = 1'b1;
      dones = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         if (o_done) dones++;
         if (i == 9) rdy = 1'b0;
      end
      chk("held rdy dones", dones, 1);
      chk("held rdy o_a", o_a, "OK ");

      @(negedge clk);
      u = 4'd7; a = "pen"; rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre-rst req", o_item_req, 1);
      rst = 1'b1;
      #1;
      chk("mid rst req", o_item_req, 0);
      chk("mid rst busy", o_busy, 0);
      chk("mid rst o_a", o_a, 0);
      chk("mid rst user", o_item_user, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      cmd("post rst bob", 4'd1, "bob", "ERR");
      cmd("post rst adm", 4'd1, "Adm", "OK ");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shop_session_ctrl.md
Name: shop_session_ctrl

Overview:
- Command sequencer in front of the shop datapath.
- Accepts one command per i_rdy pulse: opcode on i_u, 3-char ASCII name on i_a.
- Owns the user table and login session, and enforces admin/user permissions.
- Forwards item commands (add, delete, buy) to the item store over a req/ack handshake, then returns a 3-char ASCII status on o_a.

Parameters:
- I_A_NUM_BITS, 24, width of name/argument word (3 ASCII chars).
- I_U_NUM_BITS, 4, width of opcode field.
- O_A_NUM_BITS, 24, width of status word.
- MAX_USERS, 5, user table slots including admin in slot 0.
- ADMIN_USERNAME, "Adm", fixed name of slot 0; never deletable.
- ACK_TIMEOUT, 16, cycles to wait for i_item_ack before aborting.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rdy  in  1  command strobe; rising edge accepted in IDLE only.
- i_u  in  I_U_NUM_BITS  opcode.
- i_a  in  I_A_NUM_BITS  user or item name.
- o_a  out  O_A_NUM_BITS  status word, held until the next response.
- o_done  out  1  one-cycle pulse when o_a is updated.
- o_busy  out  1  high from accept until o_done, inclusive.
- o_item_req  out  1  item-store request; held until ack or timeout.
- o_item_op  out  2  0=add, 1=delete, 2=buy.
- o_item_name  out  I_A_NUM_BITS  item name, registered at accept.
- o_item_user  out  3  session slot of requester.
- i_item_ack  in  1  item store done; sampled only while o_item_req=1.
- i_item_ok  in  1  item-store result, valid with i_item_ack.

Behaviour:
- Reset (async): state IDLE; session empty; user table holds only slot 0 = ADMIN_USERNAME.
- Reset values: o_a=24'h000000; o_done, o_busy, o_item_req = 0; o_item_op, o_item_name, o_item_user = 0.
- Reset mid-operation aborts everything, including a pending o_item_req, and restores the reset state above.
- Opcodes: 0 NONE, 1 LOGIN, 2 LOGOUT, 3 ADDUSR, 4 DELUSR, 5 ADDITEM, 6 DELITEM, 7 BUY; 8-15 invalid.
- Status codes: "OK ", "ERR" (invalid op, name not found, duplicate, table full), "DEN" (permission), "TMO" (timeout).
- Accept: rising edge of i_rdy while in IDLE latches i_u and i_a. i_rdy held high yields one command. Edges while busy are ignored and never queued.
- State machine:
  - IDLE -> DECODE on accept.
  - DECODE: one cycle; table match on all slots in parallel; permission check; result goes to RESP, or to ITEM_REQ for opcodes 5-7 when permitted.
  - ITEM_REQ: assert o_item_req; -> WAIT.
  - WAIT: i_item_ack -> RESP with "OK " if i_item_ok else "ERR". Timeout counter reaches ACK_TIMEOUT -> RESP with "TMO". Either exit drops o_item_req.
  - RESP: load o_a, pulse o_done; -> IDLE.
- Latency:
  - Non-item command: o_done exactly 3 cycles after the accept edge.
  - Item command: 3 cycles + ack wait.
- Per-opcode rules:
  - NONE: "OK ", no state change.
  - LOGIN: no session and name found -> session=slot, "OK ". Session active -> "ERR". Name not found -> "ERR".
  - LOGOUT: session active -> clear, "OK "; else "ERR".
  - ADDUSR/DELUSR: admin session only, else "DEN".
  - ADDUSR: duplicate name -> "ERR". All MAX_USERS slots valid -> "ERR". Otherwise fill the lowest free slot.
  - DELUSR: name "Adm" -> "DEN"; not found -> "ERR"; else invalidate slot.
  - ADDITEM/DELITEM: admin session only, else "DEN".
  - BUY: non-admin session only; no session or admin session -> "DEN".
- Name compare is the exact 24-bit match; invalid slots never match.

Decomposition:
- shop_pkg: opcode constants, status-code constants, item op codes, ADMIN_USERNAME, FSM state encoding.
- Sub-module shop_user_table: MAX_USERS valid+name registers with add/delete ports. Outputs: match, match slot, full, free slot.

Test Plan:
- Reset, then LOGIN "Adm" -> o_a="OK " 3 cycles after the edge; session=0.
- As admin: ADDUSR "bob" x4 -> "OK ", then "ERR", "ERR", "ERR" (duplicates). ADDUSR "u2","u3","u4" -> "OK "; a fifth ADDUSR "u5" -> "ERR" (full).
- As admin: BUY "pen" -> "DEN". DELUSR "Adm" -> "DEN". ADDITEM "pen" with ack+ok after 5 cycles -> o_item_req=1, op=0, name "pen", then "OK ".
- LOGOUT; LOGIN "bob"; BUY "pen" with no ack -> o_item_req held 16 cycles, then dropped; o_a="TMO"; o_item_user=slot of bob.
- Opcode 12 -> "ERR". i_rdy pulse during WAIT is ignored (no extra o_done). i_rdy held high for 10 cycles -> single o_done.
- Assert i_reset during WAIT -> o_item_req=0 immediately; afterwards LOGIN "bob" -> "ERR" (table restored to admin-only).
